// File: rtl/btn_pkg.sv
// Shared definitions for the button front end.
// Holds the per-channel state encoding and the default timing constants
// for a 50 MHz system clock.
package btn_pkg;

  // Release debounce is a sub-flag of PRESSED, not a separate state.
  typedef enum logic [1:0] {
    ARM        = 2'd0,
    IDLE       = 2'd1,
    PRESS_WAIT = 2'd2,
    PRESSED    = 2'd3
  } chan_state_e;

  localparam int unsigned DB_CYCLES_DEF   = 500000;    // 10 ms at 50 MHz
  localparam int unsigned HOLD_CYCLES_DEF = 50000000;  // 1 s at 50 MHz
  localparam int unsigned CW_DEF          = 26;        // 2^26 > 50e6

endpackage

// File: rtl/btn_if.sv
// Button-event interface between the front end (master, producer) and the
// game/score blocks (slave, consumer).
//   p1, p2, kick      : one-cycle press pulses
//   p1_held, p2_held  : long-hold level flags
//   tie               : p1 and p2 pulsed in the same cycle
interface btn_if;
  logic p1;
  logic p2;
  logic kick;
  logic p1_held;
  logic p2_held;
  logic tie;

  modport master (output p1, p2, kick, p1_held, p2_held, tie);
  modport slave  (input  p1, p2, kick, p1_held, p2_held, tie);
endinterface

// File: rtl/btn_chan.sv
// One button channel: 2-flop synchronizer, debounce FSM, one-cycle press
// pulse and optional long-hold flag.
//   clk, reset : system clock, synchronous active-high reset
//   raw_i      : asynchronous raw button level
//   pulse_o    : one-cycle pulse per accepted press
//   held_o     : level, press held for HOLD_CYCLES (0 when HAS_HOLD = 0)
//
// state      | meaning
// ARM        | waiting for DB_CYCLES consecutive lows before accepting presses
// IDLE       | released, waiting for a high sample
// PRESS_WAIT | counting consecutive highs toward DB_CYCLES
// PRESSED    | press accepted; rel_q set while debouncing the release
module btn_chan
  import btn_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int unsigned CW          = CW_DEF,
  parameter bit          HAS_HOLD    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic pulse_o,
  output logic held_o
);

  localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES);

  logic          sync1_q, s_q;
  chan_state_e   state_q, state_d;
  logic          rel_q, rel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      s_q     <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARM;
      rel_q   <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rel_q   <= rel_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rel_d   = rel_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ARM: begin
        if (s_q) begin
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (s_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = CW'(1);
        end
      end
      PRESS_WAIT: begin
        if (!s_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = PRESSED;
          rel_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!rel_q) begin
          if (!s_q) begin
            rel_d = 1'b1;
            cnt_d = CW'(1);
          end
        end else if (s_q) begin
          // bounce during release: back to plain PRESSED, no new pulse
          rel_d = 1'b0;
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          rel_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ARM;
        rel_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // Pulse fires on the DB_CYCLES-th consecutive high sample, registered so
  // it lines up with the first cycle of PRESSED.
  always_comb begin
    pulse_d = (state_q == PRESS_WAIT) && s_q && (cnt_q == DB_LAST);
  end

  assign pulse_o = pulse_q;

  if (HAS_HOLD) begin : g_hold
    logic [CW-1:0] hold_q, hold_d;

    // Counts from zero on PRESSED entry; clearing whenever the next state is
    // not PRESSED drops held in the same cycle the channel returns to IDLE.
    always_comb begin
      hold_d = '0;
      if (state_q == PRESSED && state_d == PRESSED) begin
        hold_d = hold_q;
        if (s_q && hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) hold_q <= '0;
      else       hold_q <= hold_d;
    end

    assign held_o = (hold_q == HOLD_MAX);
  end else begin : g_no_hold
    assign held_o = 1'b0;
  end

endmodule

// File: rtl/btn_front.sv
// Push-button front end: three independent debounced channels (p1, p2,
// kick) driving the button-event interface, plus the p1/p2 tie flag.
//   clk, reset                : system clock, synchronous active-high reset
//   p1_raw, p2_raw, kick_raw  : asynchronous raw button levels
//   evt (btn_if.master)       : press pulses, held flags, tie
module btn_front
  import btn_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int unsigned CW          = CW_DEF
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  p1_raw,
  input  logic  p2_raw,
  input  logic  kick_raw,
  btn_if.master evt
);

  logic p1_pulse, p2_pulse, kick_pulse;
  logic p1_held, p2_held, kick_held_unused;

  btn_chan #(.DB_CYCLES(DB_CYCLES), .HOLD_CYCLES(HOLD_CYCLES), .CW(CW), .HAS_HOLD(1'b1))
    u_p1 (.clk(clk), .reset(reset), .raw_i(p1_raw), .pulse_o(p1_pulse), .held_o(p1_held));

  btn_chan #(.DB_CYCLES(DB_CYCLES), .HOLD_CYCLES(HOLD_CYCLES), .CW(CW), .HAS_HOLD(1'b1))
    u_p2 (.clk(clk), .reset(reset), .raw_i(p2_raw), .pulse_o(p2_pulse), .held_o(p2_held));

  btn_chan #(.DB_CYCLES(DB_CYCLES), .HOLD_CYCLES(HOLD_CYCLES), .CW(CW), .HAS_HOLD(1'b0))
    u_kick (.clk(clk), .reset(reset), .raw_i(kick_raw), .pulse_o(kick_pulse),
            .held_o(kick_held_unused));

  assign evt.p1      = p1_pulse;
  assign evt.p2      = p2_pulse;
  assign evt.kick    = kick_pulse;
  assign evt.p1_held = p1_held;
  assign evt.p2_held = p2_held;
  // Both pulses are still delivered; the game FSM arbitrates.
  assign evt.tie     = p1_pulse & p2_pulse;

endmodule

// File: tb/tb_btn_front.sv
// Directed bench for btn_front with DB_CYCLES=4, HOLD_CYCLES=16, CW=8.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
// Index i counts ticks from the first high raw sample, so a clean press
// pulses at i == 5 (2 sync stages + 4th stable sample).
module tb_btn_front;

  logic clk = 1'b0;
  logic reset, p1_raw, p2_raw, kick_raw;
  int   checks = 0;
  int   errors = 0;

  btn_if evt ();

  btn_front #(.DB_CYCLES(4), .HOLD_CYCLES(16), .CW(8)) dut (
    .clk(clk), .reset(reset), .p1_raw(p1_raw), .p2_raw(p2_raw),
    .kick_raw(kick_raw), .evt(evt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".p1"}, evt.p1, 1'b0);
    chk({tag, ".p2"}, evt.p2, 1'b0);
    chk({tag, ".kick"}, evt.kick, 1'b0);
    chk({tag, ".p1_held"}, evt.p1_held, 1'b0);
    chk({tag, ".p2_held"}, evt.p2_held, 1'b0);
    chk({tag, ".tie"}, evt.tie, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; p1_raw = 1'b0; p2_raw = 1'b0; kick_raw = 1'b0;
    idle(3);
    chk_all_zero("reset");
    reset = 1'b0;

    // clean press on p1
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("arm_p1", evt.p1, 1'b0);
    end
    p1_raw = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("clean_p1", evt.p1, i == 5);
      chk("clean_held", evt.p1_held, 1'b0);
      chk("clean_tie", evt.tie, 1'b0);
    end
    p1_raw = 1'b0;
    idle(8);

    // bounce rejection on p2, then a stable press
    begin
      logic [6:0] pat;
      pat = 7'b1101110;  // applied MSB first: 1,1,0,1,1,1,0
      for (int i = 6; i >= 0; i--) begin
        p2_raw = pat[i];
        tick();
        chk("bounce_p2", evt.p2, 1'b0);
      end
    end
    for (int i = 0; i < 10; i++) begin
      p2_raw = (i < 4);
      tick();
      chk("stable_p2", evt.p2, i == 5);
      chk("stable_p2_held", evt.p2_held, 1'b0);
    end
    idle(8);

    // long hold on p1: held rises 16 cycles after the pulse
    p1_raw = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("hold_p1", evt.p1, i == 5);
      chk("hold_held", evt.p1_held, i >= 21);
    end
    p1_raw = 1'b0;
    // held falls on the 4th low synchronized sample
    for (int j = 0; j < 10; j++) begin
      tick();
      chk("release_held", evt.p1_held, j < 5);
      chk("release_p1", evt.p1, 1'b0);
    end
    idle(4);

    // tie
    p1_raw = 1'b1; p2_raw = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("tie_p1", evt.p1, i == 5);
      chk("tie_p2", evt.p2, i == 5);
      chk("tie", evt.tie, i == 5);
    end
    p1_raw = 1'b0; p2_raw = 1'b0;
    idle(8);

    // kick held through reset
    reset = 1'b1; kick_raw = 1'b1;
    idle(3);
    chk_all_zero("kick_reset");
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("kick_through_reset", evt.kick, 1'b0);
    end
    kick_raw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("kick_low", evt.kick, 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      kick_raw = (i < 4);
      tick();
      chk("kick_press", evt.kick, i == 5);
    end
    idle(8);

    // reset during PRESS_WAIT of p1
    p1_raw = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midpress_p1", evt.p1, 1'b0);
    end
    reset = 1'b1;
    tick();
    chk_all_zero("midpress_reset");
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("midpress_after", evt.p1, 1'b0);
    end
    // three lows are not enough to re-arm
    p1_raw = 1'b0;
    idle(3);
    p1_raw = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("short_arm_p1", evt.p1, 1'b0);
    end
    p1_raw = 1'b0;
    idle(6);
    p1_raw = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rearm_p1", evt.p1, i == 5);
    end
    p1_raw = 1'b0;
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
